calc_controller: RTL and testbench
==================================

CALC_CONTROLLER -- requirements
Module: calc_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles needed to accept an ENTER_N level change; integer 2 to 2^20 (board build overrides to 500000).
REQ-002 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-003 RESET_N  input  1  synchronous, active-low reset, sampled on the CLOCK_50 rising edge.
REQ-004 SW  input  8  operand entry, two's-complement signed.
REQ-005 OP  input  1  function select: 0 = add, 1 = subtract; sampled only when B is captured.
REQ-006 ENTER_N  input  1  raw active-low pushbutton, asynchronous to CLOCK_50, may bounce.
REQ-007 DISP  output  8  registered value for the 8-bit signed display path.
REQ-008 OVF  output  1  registered signed-overflow flag of the last result.
REQ-009 PHASE  output  2  registered state code: 0 = ENTER_A, 1 = ENTER_B, 2 = EXEC, 3 = SHOW.

Function
REQ-010 ENTER_N SHALL pass through a 2-flop synchronizer before any other use; both flops reset to 1.
REQ-011 Debounce: a counter clears whenever the synchronized value equals the stable level, and increments while they differ.
REQ-012 When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch, the stable level SHALL take the synchronized value and the counter SHALL clear.
REQ-013 A one-cycle press pulse SHALL assert in the cycle after the stable level goes 1->0; a 0->1 transition produces no pulse.
REQ-014 A key held low indefinitely SHALL produce exactly one pulse; glitches shorter than DEBOUNCE_CYCLES SHALL produce none.
REQ-015 FSM ENTER_A: DISP <= SW every cycle; on press, A <= SW and go to ENTER_B.
REQ-016 FSM ENTER_B: DISP <= SW every cycle; on press, B <= SW and opreg <= OP, and go to EXEC.
REQ-017 FSM EXEC: one cycle long; compute R = A+B (opreg=0) or A-B (opreg=1) as an 8-bit wrapped result.
REQ-018 In EXEC, DISP <= R and OVF <= signed overflow: operands share a sign (B inverted for subtract) and R's sign differs; then go to SHOW unconditionally.
REQ-019 FSM SHOW: DISP and OVF hold; on press, clear OVF and go to ENTER_A (DISP resumes tracking SW on the following cycle).
REQ-020 A press pulse coincident with EXEC SHALL be ignored.
REQ-021 Press-to-state-change latency SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after ENTER_N falls, given a clean edge.
REQ-022 OP and SW changes outside their capture cycles SHALL NOT affect A, B, opreg, OVF or DISP in SHOW.
REQ-023 A result of -128 (0x80) without overflow SHALL be valid; OVF depends only on REQ-018.

Reset
REQ-024 With RESET_N low at a clock edge: PHASE = 0 (ENTER_A), A = B = 0, opreg = 0, DISP = 0x00, OVF = 0, debounce counter = 0, stable level = 1, synchronizer flops = 1.
REQ-025 Reset SHALL override any in-progress debounce or FSM step; a press pulse in the reset cycle is discarded.
REQ-026 Key still held low when reset releases: no press pulse until the key is released and pressed again (stable level re-learns low without generating a pulse).
REQ-027 No output SHALL be X after the first reset edge.

Verification (DEBOUNCE_CYCLES = 4)
REQ-028 SW=0x19, press; SW=0xF9, OP=0, press -> PHASE=3, DISP=0x12, OVF=0.
REQ-029 A=0x7F, B=0xFF, OP=1 -> DISP=0x80, OVF=1; A=0x80, B=0x80, OP=0 -> DISP=0x00, OVF=1.
REQ-030 ENTER_N low for 3 cycles, high for 3 cycles, repeated 10 times -> PHASE stays 0, no press pulse.
REQ-031 ENTER_N held low for 100 cycles in ENTER_A -> exactly one transition to PHASE=1.
REQ-032 In ENTER_B with A=0x05 captured, RESET_N low 1 cycle -> PHASE=0, DISP=0x00, OVF=0; a new full sequence then uses fresh A.
REQ-033 In SHOW, toggle SW and OP with no press -> DISP and OVF unchanged; press -> PHASE=0, OVF=0, DISP=SW one cycle later.

Source files
------------

// File: rtl/calc_controller.sv
// calc_controller: debounced single-key two-operand signed add/subtract calculator
module calc_controller #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [7:0] SW,
    input  logic       OP,
    input  logic       ENTER_N,
    output logic [7:0] DISP,
    output logic       OVF,
    output logic [1:0] PHASE
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        EXEC    = 2'd2,
        SHOW    = 2'd3
    } state_t;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [1:0]    vld_q, vld_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          armed_q, armed_d;
    logic          press_q, press_d;

    state_t        state_q, state_d;
    logic [7:0]    a_q, a_d;
    logic [7:0]    b_q, b_d;
    logic          op_q, op_d;
    logic [7:0]    disp_q, disp_d;
    logic          ovf_q, ovf_d;

    logic [7:0]    b_eff;
    logic [7:0]    result;
    logic          result_ovf;

    // Key path: synchronize, debounce, and emit one press pulse per debounced fall.
    // The key is only armed once a valid synchronized sample shows it released,
    // so a key held through reset re-learns low silently.
    always_comb begin
        sync1_d  = ENTER_N;
        sync2_d  = sync1_q;
        vld_d    = {vld_q[0], 1'b1};
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        armed_d = armed_q | (vld_q[1] & sync2_q & stable_q);
        press_d = armed_q & stable_q & ~stable_d;
    end

    // Calculator FSM: capture A, capture B and OP, execute for one cycle, show result.
    always_comb begin
        b_eff      = op_q ? ~b_q : b_q;
        result     = a_q + b_eff + {7'd0, op_q};
        result_ovf = (a_q[7] == b_eff[7]) & (result[7] != a_q[7]);
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        unique case (state_q)
            ENTER_A: begin
                disp_d = SW;
                if (press_q) begin
                    a_d     = SW;
                    state_d = ENTER_B;
                end
            end
            ENTER_B: begin
                disp_d = SW;
                if (press_q) begin
                    b_d     = SW;
                    op_d    = OP;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                disp_d  = result;
                ovf_d   = result_ovf;
                state_d = SHOW;
            end
            SHOW: begin
                if (press_q) begin
                    ovf_d   = 1'b0;
                    state_d = ENTER_A;
                end
            end
            default: state_d = ENTER_A;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            vld_q    <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b1;
            armed_q  <= 1'b0;
            press_q  <= 1'b0;
            state_q  <= ENTER_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            disp_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            vld_q    <= vld_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            armed_q  <= armed_d;
            press_q  <= press_d;
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            disp_q   <= disp_d;
            ovf_q    <= ovf_d;
        end
    end

    assign DISP  = disp_q;
    assign OVF   = ovf_q;
    assign PHASE = state_q;

endmodule

// File: tb/tb_calc_controller.sv
// tb_calc_controller: randomized self-checking bench for calc_controller against an arithmetic model
module tb_calc_controller;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw = 8'h00;
    logic       op = 1'b0;
    logic       enter_n = 1'b1;
    logic [7:0] disp;
    logic       ovf;
    logic [1:0] phase;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    calc_controller #(.DEBOUNCE_CYCLES(N)) dut (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .SW      (sw),
        .OP      (op),
        .ENTER_N (enter_n),
        .DISP    (disp),
        .OVF     (ovf),
        .PHASE   (phase)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(5);
    endtask

    // Clean press long enough to be accepted, then a release long enough to settle.
    task automatic press();
        enter_n = 1'b0;
        tick(N + 4);
        enter_n = 1'b1;
        tick(N + 4);
    endtask

    // Signed arithmetic model: overflow means the true integer result is out of 8-bit range.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic o,
                                  output logic [7:0] r, output logic v);
        int sa, sb, s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        s  = o ? sa - sb : sa + sb;
        r  = s[7:0];
        v  = (s > 127) || (s < -128);
    endfunction

    task automatic run_calc(input string name, input logic [7:0] a, input logic [7:0] b, input logic o);
        logic [7:0] er;
        logic       ev;
        model(a, b, o, er, ev);
        sw = a;
        press();
        sw = b;
        op = o;
        press();
        sw = 8'($urandom);
        op = 1'($urandom);
        tick(2);
        n_cmp++;
        if (phase !== 2'd3) begin
            n_bad++;
            $display("FAIL %s_phase: got %0d want 3", name, phase);
        end
        n_cmp++;
        if (disp !== er) begin
            n_bad++;
            $display("FAIL %s_disp: got %02h want %02h (a=%02h b=%02h op=%0b)", name, disp, er, a, b, o);
        end
        n_cmp++;
        if (ovf !== ev) begin
            n_bad++;
            $display("FAIL %s_ovf: got %0b want %0b (a=%02h b=%02h op=%0b)", name, ovf, ev, a, b, o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sw = 8'hA5;
        tick(2);
        n_cmp++;
        if (phase !== 2'd0 || disp !== 8'h00 || ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got phase=%0d disp=%02h ovf=%0b want 0/00/0", phase, disp, ovf);
        end
        rst_n = 1'b1;
        tick(5);
        sw = 8'h3C;
        tick();
        n_cmp++;
        if (disp !== 8'h3C) begin
            n_bad++;
            $display("FAIL reset_track_sw: got %02h want 3c", disp);
        end
    endtask

    task automatic test_add();
        do_reset();
        run_calc("add", 8'h19, 8'hF9, 1'b0);
    endtask

    task automatic test_overflow();
        do_reset();
        run_calc("sub_ovf", 8'h7F, 8'hFF, 1'b1);
        press();
        run_calc("add_ovf", 8'h80, 8'h80, 1'b0);
        press();
        run_calc("min_no_ovf", 8'hC0, 8'hC0, 1'b0);
    endtask

    task automatic test_latency();
        do_reset();
        sw = 8'h11;
        enter_n = 1'b0;
        tick(N + 2);
        n_cmp++;
        if (phase !== 2'd0) begin
            n_bad++;
            $display("FAIL latency_early: got %0d want 0", phase);
        end
        tick();
        n_cmp++;
        if (phase !== 2'd1) begin
            n_bad++;
            $display("FAIL latency_exact: got %0d want 1", phase);
        end
        enter_n = 1'b1;
        tick(N + 4);
    endtask

    task automatic test_glitch();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            enter_n = 1'b0;
            tick(3);
            enter_n = 1'b1;
            tick(3);
            n_cmp++;
            if (phase !== 2'd0) begin
                n_bad++;
                $display("FAIL glitch_iter%0d: got %0d want 0", i, phase);
            end
        end
        tick(N + 4);
        n_cmp++;
        if (phase !== 2'd0) begin
            n_bad++;
            $display("FAIL glitch_final: got %0d want 0", phase);
        end
    endtask

    task automatic test_hold();
        int changes;
        logic [1:0] prev;
        do_reset();
        changes = 0;
        prev = phase;
        enter_n = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (phase !== prev) changes++;
            prev = phase;
        end
        n_cmp++;
        if (changes != 1 || phase !== 2'd1) begin
            n_bad++;
            $display("FAIL hold_one_press: got changes=%0d phase=%0d want 1/1", changes, phase);
        end
        enter_n = 1'b1;
        tick(N + 4);
    endtask

    task automatic test_mid_reset();
        do_reset();
        sw = 8'h05;
        press();
        n_cmp++;
        if (phase !== 2'd1) begin
            n_bad++;
            $display("FAIL midreset_enter_b: got %0d want 1", phase);
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (phase !== 2'd0 || disp !== 8'h00 || ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_state: got phase=%0d disp=%02h ovf=%0b want 0/00/0", phase, disp, ovf);
        end
        rst_n = 1'b1;
        tick(5);
        run_calc("midreset_fresh", 8'h10, 8'h03, 1'b0);
    endtask

    task automatic test_show_hold();
        logic [7:0] d0;
        logic       v0;
        do_reset();
        run_calc("show", 8'h7F, 8'h01, 1'b0);
        d0 = 8'h80;
        v0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sw = 8'($urandom);
            op = 1'($urandom);
            tick();
            n_cmp++;
            if (disp !== d0 || ovf !== v0) begin
                n_bad++;
                $display("FAIL show_hold%0d: got disp=%02h ovf=%0b want %02h/%0b", i, disp, ovf, d0, v0);
            end
        end
        sw = 8'h5A;
        enter_n = 1'b0;
        tick(N + 3);
        n_cmp++;
        if (phase !== 2'd0 || ovf !== 1'b0 || disp !== d0) begin
            n_bad++;
            $display("FAIL show_exit: got phase=%0d ovf=%0b disp=%02h want 0/0/%02h", phase, ovf, disp, d0);
        end
        tick();
        n_cmp++;
        if (disp !== 8'h5A) begin
            n_bad++;
            $display("FAIL show_resume_sw: got %02h want 5a", disp);
        end
        enter_n = 1'b1;
        tick(N + 4);
    endtask

    task automatic test_held_through_reset();
        enter_n = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(30);
        n_cmp++;
        if (phase !== 2'd0) begin
            n_bad++;
            $display("FAIL held_reset_nopulse: got %0d want 0", phase);
        end
        enter_n = 1'b1;
        tick(N + 6);
        n_cmp++;
        if (phase !== 2'd0) begin
            n_bad++;
            $display("FAIL held_reset_release: got %0d want 0", phase);
        end
        press();
        n_cmp++;
        if (phase !== 2'd1) begin
            n_bad++;
            $display("FAIL held_reset_repress: got %0d want 1", phase);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            run_calc($sformatf("rand%0d", i), 8'($urandom), 8'($urandom), 1'($urandom));
            press();
            n_cmp++;
            if (phase !== 2'd0) begin
                n_bad++;
                $display("FAIL rand%0d_return: got %0d want 0", i, phase);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_calc("b2b_0", 8'h01, 8'h02, 1'b1);
        press();
        run_calc("b2b_1", 8'h80, 8'h01, 1'b1);
        press();
        run_calc("b2b_2", 8'h00, 8'h80, 1'b1);
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_latency();
        test_glitch();
        test_hold();
        test_mid_reset();
        test_show_hold();
        test_held_through_reset();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
